mem_access_unit: RTL and testbench

- Memory interface stage directly downstream of the LC-3 control unit; it executes the memory cycles requested via MIO_EN/R_W.
- Drives the off-chip async SRAM from the MAR address and MDR write data.
- Returns read data toward MDR and a Mem_Ready handshake (LC-3 "R") that the control unit polls before leaving memory states.
- Optionally decodes the memory-mapped I/O location xFFFF.

---
 rtl/lc3_mem_pkg.sv | 34 +++
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared definitions for the LC-3 memory access stage.
//   - state_e     : access sequencer states (IDLE, SETUP, ACCESS, DONE)
//   - MMIO_ADDR   : memory-mapped I/O location (switches / hex display)
//   - SRAM_AW_DEFAULT : default SRAM address width
//   - WAIT_MIN/WAIT_MAX, wait_load(): legal strobe-active cycle range and
//     the wait-counter preload derived from it
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] MMIO_ADDR       = 16'hFFFF;
  localparam int          SRAM_AW_DEFAULT = 20;

  // Strobe-active cycles per access must lie in WAIT_MIN..WAIT_MAX.
  localparam int WAIT_MIN   = 1;
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = 4;

  // Counter preload (cycles - 1). Out-of-range settings are clamped to the
  // legal range so the counter can never wrap and stall the sequencer.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
    int c;
    c = cycles;
    if (c < WAIT_MIN) c = WAIT_MIN;
    if (c > WAIT_MAX) c = WAIT_MAX;
    return WAIT_CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: LC-3 memory interface stage. Runs one SRAM cycle per
// MIO_EN request from the control unit and answers with Mem_Ready.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   MIO_EN, R_W            request (held until Mem_Ready), 1 = write
//   MAR, MDR_Out           access address and write data (latched at request)
//   Switches               MMIO read source
//   Data_from_SRAM         SRAM read data
//   Data_to_CPU            read data, valid while Mem_Ready = 1
//   Mem_Ready              access complete ("R")
//   ADDR, Data_to_SRAM     SRAM address / write data
//   Data_oe                SRAM data-bus tristate enable
//   CE_N, OE_N, WE_N, UB_N, LB_N  SRAM strobes, active low
//   Hex_Out                MMIO display register
//
// Build option: define MMIO_EN to decode xFFFF as memory-mapped I/O
// (single-cycle, no SRAM strobes). Without it xFFFF is plain SRAM and
// Hex_Out is constant 0.
//
// All SRAM-facing outputs are registers computed from the next state, so the
// strobes never glitch and a reset or abort releases them on the same edge.
module mem_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               MIO_EN,
  input  logic               R_W,
  input  logic [15:0]        MAR,
  input  logic [15:0]        MDR_Out,
  input  logic [15:0]        Switches,
  input  logic [15:0]        Data_from_SRAM,
  output logic [15:0]        Data_to_CPU,
  output logic               Mem_Ready,
  output logic [SRAM_AW-1:0] ADDR,
  output logic [15:0]        Data_to_SRAM,
  output logic               Data_oe,
  output logic               CE_N,
  output logic               OE_N,
  output logic               WE_N,
  output logic               UB_N,
  output logic               LB_N,
  output logic [15:0]        Hex_Out
);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic                    mmio_q, mmio_d;
  logic [15:0]             addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             rdata_q, rdata_d;
  logic [15:0]             hex_q, hex_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    byte_n_q, byte_n_d;
  logic                    data_oe_q, data_oe_d;
  logic                    ready_q, ready_d;
  logic                    sram_active;

`ifndef MMIO_EN
  // Switches only feed the MMIO read path.
  logic unused_switches;
  assign unused_switches = ^Switches;
`endif

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    mmio_d  = mmio_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    unique case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          rw_d   = R_W;
          mmio_d = 1'b0;
`ifdef MMIO_EN
          if (MAR == MMIO_ADDR) begin
            // I/O location: completes without touching the SRAM pins.
            mmio_d  = 1'b1;
            state_d = DONE;
            if (R_W) hex_d   = MDR_Out;
            else     rdata_d = Switches;
          end else begin
            addr_d  = MAR;
            wdata_d = MDR_Out;
            cnt_d   = wait_load(WAIT_CYCLES);
            state_d = SETUP;
          end
`else
          addr_d  = MAR;
          wdata_d = MDR_Out;
          cnt_d   = wait_load(WAIT_CYCLES);
          state_d = SETUP;
`endif
        end
      end
      SETUP: begin
        state_d = MIO_EN ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (!MIO_EN) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          if (!rw_q) rdata_d = Data_from_SRAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered pin outputs decoded from the state being entered.
  always_comb begin
    sram_active = (state_d == SETUP) || (state_d == ACCESS);
    ce_n_d      = !sram_active;
    byte_n_d    = !sram_active;
    oe_n_d      = !(sram_active && !rw_d);
    // WE_N stays high during SETUP to give the address setup time.
    we_n_d      = !((state_d == ACCESS) && rw_d);
    // Write data is driven from SETUP through the first DONE cycle (hold).
    data_oe_d   = rw_d && !mmio_d &&
                  (sram_active || ((state_d == DONE) && (state_q != DONE)));
    // Ready follows one cycle into DONE and tracks the request afterwards.
    ready_d     = (state_q == DONE) && MIO_EN;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      mmio_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hex_q     <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      byte_n_q  <= 1'b1;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      mmio_q    <= mmio_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      byte_n_q  <= byte_n_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
    end
  end

  assign ADDR         = SRAM_AW'(addr_q);
  assign Data_to_SRAM = wdata_q;
  assign Data_to_CPU  = rdata_q;
  assign Mem_Ready    = ready_q;
  assign Data_oe      = data_oe_q;
  assign CE_N         = ce_n_q;
  assign OE_N         = oe_n_q;
  assign WE_N         = we_n_q;
  assign UB_N         = byte_n_q;
  assign LB_N         = byte_n_q;
  assign Hex_Out      = hex_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit.
// A behavioural SRAM sits on the pins; the reference model is a plain
// address->data map plus latency/strobe-count rules for each access kind.
module tb_mem_access_unit;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          Clk = 1'b0;
  logic          Reset, MIO_EN, R_W;
  logic [15:0]   MAR, MDR_Out, Switches, Data_from_SRAM;
  logic [15:0]   Data_to_CPU, Data_to_SRAM, Hex_Out;
  logic          Mem_Ready, Data_oe, CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [AW-1:0] ADDR;

  mem_access_unit #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
    .MDR_Out(MDR_Out), .Switches(Switches), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready), .ADDR(ADDR),
    .Data_to_SRAM(Data_to_SRAM), .Data_oe(Data_oe), .CE_N(CE_N),
    .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N), .Hex_Out(Hex_Out)
  );

  always #5 Clk = ~Clk;

  // Behavioural async SRAM (write sampled while WE_N low and bus driven).
  logic [15:0] sram [0:65535];
  assign Data_from_SRAM = (CE_N === 1'b0 && OE_N === 1'b0) ? sram[ADDR[15:0]] : 16'h0000;
  always @(posedge Clk)
    if (CE_N === 1'b0 && WE_N === 1'b0 && Data_oe === 1'b1)
      sram[ADDR[15:0]] <= Data_to_SRAM;

  // Reference model state.
  logic [15:0] ref_mem [int];
  logic [15:0] last_read = 16'h0;
  logic [15:0] last_hex  = 16'h0;
  int          written_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] data, input int hold);
    bit mmio;
    int lat, exp_lat, oe_lo, we_lo, ce_lo, doe_hi, we_setup, byte_bad;
    logic [15:0] exp_rd;
    mmio = 1'b0;
`ifdef MMIO_EN
    mmio = (addr == 16'hFFFF);
`endif
    exp_lat = mmio ? 2 : 3 + W;
    oe_lo = 0; we_lo = 0; ce_lo = 0; doe_hi = 0; we_setup = 0; byte_bad = 0; lat = 0;
    MIO_EN = 1'b1; R_W = wr; MAR = addr; MDR_Out = data;
    while (Mem_Ready !== 1'b1 && lat < 40) begin
      tick;
      lat++;
      if (lat == 1) begin
        if (WE_N === 1'b0) we_setup++;
        // Request fields after the latch edge must be ignored.
        R_W = 1'($urandom); MAR = 16'($urandom); MDR_Out = 16'($urandom);
      end
      if (OE_N === 1'b0) oe_lo++;
      if (WE_N === 1'b0) we_lo++;
      if (CE_N === 1'b0) ce_lo++;
      if (Data_oe === 1'b1) doe_hi++;
      if (UB_N !== CE_N || LB_N !== CE_N) byte_bad++;
    end
    check("latency", lat, exp_lat);
    check("byte_strobes", byte_bad, 0);
    if (mmio) begin
      check("mmio_ce", ce_lo, 0);
      check("mmio_oe", doe_hi, 0);
      if (wr) begin
        last_hex = data;
      end else begin
        last_read = Switches;
      end
      check("mmio_hex", Hex_Out, last_hex);
      check("mmio_rd", Data_to_CPU, last_read);
    end else if (wr) begin
      check("wr_we_cycles", we_lo, W);
      check("wr_we_setup", we_setup, 0);
      check("wr_oe_cycles", oe_lo, 0);
      check("wr_ce_cycles", ce_lo, W + 1);
      check("wr_data_oe", doe_hi, W + 2);
      check("wr_sram", sram[addr], data);
      check("wr_rd_hold", Data_to_CPU, last_read);
      ref_mem[addr] = data;
      written_q.push_back(addr);
    end else begin
      exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0;
      check("rd_oe_cycles", oe_lo, W + 1);
      check("rd_we_cycles", we_lo, 0);
      check("rd_ce_cycles", ce_lo, W + 1);
      check("rd_data_oe", doe_hi, 0);
      check("rd_data", Data_to_CPU, exp_rd);
      last_read = exp_rd;
    end
    for (int i = 0; i < hold; i++) begin
      tick;
      check("ready_hold", Mem_Ready, 1);
      check("no_reissue", CE_N, 1);
    end
    MIO_EN = 1'b0;
    tick;
    check("ready_drop", Mem_Ready, 0);
    $display("txn %s addr=%04h data=%04h latency=%0d hold=%0d cpu=%04h",
             wr ? "WR" : "RD", addr, wr ? data : Data_to_CPU, lat, hold, Data_to_CPU);
  endtask

  initial begin
    logic [15:0] a, d;
    Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; MAR = 16'h0; MDR_Out = 16'h0; Switches = 16'h0;
    tick; tick;
    check("rst_ce", CE_N, 1);
    check("rst_oe", OE_N, 1);
    check("rst_we", WE_N, 1);
    check("rst_ublb", {UB_N, LB_N}, 2'b11);
    check("rst_data_oe", Data_oe, 0);
    check("rst_ready", Mem_Ready, 0);
    check("rst_addr", ADDR, 0);
    check("rst_wdata", Data_to_SRAM, 0);
    check("rst_cpu", Data_to_CPU, 0);
    check("rst_hex", Hex_Out, 0);
    Reset = 1'b0;
    tick;

    // Directed: write then read x3000, write xBEEF with extended hold.
    access(1'b1, 16'h3000, 16'h1234, 0);
    access(1'b0, 16'h3000, 16'h0000, 0);
    access(1'b1, 16'h0010, 16'hBEEF, 3);
    access(1'b0, 16'h0010, 16'h0000, 1);

    // Abort during SETUP.
    MIO_EN = 1'b1; R_W = 1'b0; MAR = 16'h3000;
    tick;
    check("abort_setup_oe", OE_N, 0);
    MIO_EN = 1'b0;
    tick;
    check("abort_ce", CE_N, 1);
    check("abort_oe", OE_N, 1);
    check("abort_ready", Mem_Ready, 0);
    tick;
    check("abort_ready2", Mem_Ready, 0);
    check("abort_cpu", Data_to_CPU, last_read);
    $display("txn ABORT addr=3000");

    // Reset during ACCESS of a write.
    MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'h0200; MDR_Out = 16'h5555;
    tick; tick;
    check("rstmid_we_access", WE_N, 0);
    Reset = 1'b1;
    tick;
    check("rstmid_strobes", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'b11111);
    check("rstmid_data_oe", Data_oe, 0);
    check("rstmid_ready", Mem_Ready, 0);
    Reset = 1'b0; MIO_EN = 1'b0;
    last_read = 16'h0; last_hex = 16'h0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rstmid_ready_low", Mem_Ready, 0);
    end
    $display("txn RESET_MID_WRITE addr=0200");

`ifdef MMIO_EN
    access(1'b1, 16'hFFFF, 16'hA5A5, 0);
    Switches = 16'h0042;
    access(1'b0, 16'hFFFF, 16'h0000, 1);
`endif

    // Randomized mix of reads and writes.
    for (int n = 0; n < 24; n++) begin
      Switches = 16'($urandom);
      if (written_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 16'($urandom_range(0, 16'hFFFE));
        d = 16'($urandom);
        access(1'b1, a, d, $urandom_range(0, 2));
      end else begin
        a = 16'(written_q[$urandom_range(0, written_q.size() - 1)]);
        access(1'b0, a, 16'h0000, $urandom_range(0, 2));
      end
    end

    check("final_hex", Hex_Out, last_hex);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
